// File: rtl/pc_ras_update.sv
// Program-counter update with an optional return-address stack (RAS) for call/ret prediction.
// Define PC_RAS_UPDATE_RAS_EN to build the stack; when undefined the RAS outputs are tied off.
module pc_ras_update #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [ADDR_W-1:0] valC,
  input  logic [ADDR_W-1:0] valM,
  input  logic [ADDR_W-1:0] valP,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ras_pred,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_mispredict,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_CALL = 4'h8;
  localparam logic [3:0] IC_RET  = 4'h9;

  if ((RAS_DEPTH < 2) || (RAS_DEPTH > 64) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_ras_update: RAS_DEPTH must be a power of two in 2..64");
  end

  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] pc_r;

  // Next-pc selection from the instruction code.
  always_comb begin
    next_pc_s = valP;
    case (icode)
      IC_JXX: begin
        if (cnd) begin
          next_pc_s = valC;
        end else begin
          next_pc_s = valP;
        end
      end
      IC_CALL: next_pc_s = valC;
      IC_RET:  next_pc_s = valM;
      default: next_pc_s = valP;
    endcase
  end

  // Program-counter register; reset dominates stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (!stall) begin
      pc_r <= next_pc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

`ifdef PC_RAS_UPDATE_RAS_EN
  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] stack_r [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_r;
  logic [PTR_W-1:0]  top_idx_s;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] pred_s;
  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              ret_s;
  logic              pop_s;
  logic              mispredict_r;
  logic              overflow_r;
  logic              underflow_r;

  // sp_r addresses the next free slot; when full it also addresses the oldest entry,
  // so a push while full overwrites the oldest return address.
  assign top_idx_s = sp_r - PTR_W'(1);
  assign empty_s   = (count_r == '0);
  assign full_s    = (count_r == DEPTH_C);

  // Stack control decode and top-of-stack prediction.
  always_comb begin
    push_s = 1'b0;
    ret_s  = 1'b0;
    pop_s  = 1'b0;
    pred_s = '0;
    if (!stall && (icode == IC_CALL)) begin
      push_s = 1'b1;
    end else if (!stall && (icode == IC_RET)) begin
      ret_s = 1'b1;
      pop_s = !empty_s;
    end else begin
      push_s = 1'b0;
    end
    if (empty_s) begin
      pred_s = '0;
    end else begin
      pred_s = stack_r[top_idx_s];
    end
  end

  // Pointer, occupancy and event-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r         <= '0;
      count_r      <= '0;
      mispredict_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      mispredict_r <= pop_s && (valM != pred_s);
      overflow_r   <= push_s && full_s;
      underflow_r  <= ret_s && empty_s;
      if (push_s) begin
        sp_r <= sp_r + PTR_W'(1);
        if (!full_s) begin
          count_r <= count_r + CNT_W'(1);
        end else begin
          count_r <= count_r;
        end
      end else if (pop_s) begin
        sp_r    <= top_idx_s;
        count_r <= count_r - CNT_W'(1);
      end else begin
        sp_r    <= sp_r;
        count_r <= count_r;
      end
    end
  end

  // Return-address storage; entries are not cleared on reset.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      stack_r[sp_r] <= valP;
    end
  end

  assign ras_pred       = pred_s;
  assign ras_empty      = empty_s;
  assign ras_full       = full_s;
  assign ras_mispredict = mispredict_r;
  assign ras_overflow   = overflow_r;
  assign ras_underflow  = underflow_r;
`else
  assign ras_pred       = '0;
  assign ras_empty      = 1'b1;
  assign ras_full       = 1'b0;
  assign ras_mispredict = 1'b0;
  assign ras_overflow   = 1'b0;
  assign ras_underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ras_update.sv
// Self-checking bench for pc_ras_update: directed scenarios plus randomized traffic checked
// against a queue-based return-address model (RAS expectations follow PC_RAS_UPDATE_RAS_EN).
module tb_pc_ras_update;

  localparam int          DEPTH = 8;
  localparam logic [63:0] RST_PC = 64'h0000_0000_0000_1000;
`ifdef PC_RAS_UPDATE_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, cnd;
  logic [3:0]  icode;
  logic [63:0] valC, valM, valP;
  logic [63:0] pc, ras_pred;
  logic        ras_empty, ras_full, ras_mispredict, ras_overflow, ras_underflow;

  pc_ras_update #(.ADDR_W(64), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .icode(icode), .cnd(cnd),
    .valC(valC), .valM(valM), .valP(valP), .pc(pc), .ras_pred(ras_pred),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_mispredict(ras_mispredict),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of return addresses, newest at the back.
  logic [63:0] q[$];
  logic [63:0] exp_pc;
  logic        exp_mis, exp_ovf, exp_unf;

  function automatic logic [63:0] m_pred();
    if (q.size() == 0) return 64'h0;
    return q[$];
  endfunction

  task automatic do_cycle(input logic rst, input logic st, input logic [3:0] ic, input logic c,
                          input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp);
    reset = rst; stall = st; icode = ic; cnd = c; valC = vc; valM = vm; valP = vp;
    @(posedge clk);
    exp_mis = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    if (rst) begin
      exp_pc = RST_PC;
      q.delete();
    end else if (!st) begin
      case (ic)
        4'h7:    exp_pc = c ? vc : vp;
        4'h8:    exp_pc = vc;
        4'h9:    exp_pc = vm;
        default: exp_pc = vp;
      endcase
      if (RAS_ON && ic == 4'h8) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          exp_ovf = 1'b1;
        end
        q.push_back(vp);
      end else if (RAS_ON && ic == 4'h9) begin
        if (q.size() == 0) exp_unf = 1'b1;
        else begin
          exp_mis = (vm != q[$]);
          void'(q.pop_back());
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 64'h0, 64'h0, 64'h0);
    do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 64'h0, 64'h0, 64'h0);
    n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
    n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", ras_full); end
    n_checks++; if (ras_pred !== 64'h0) begin n_fail++; $display("FAIL reset_pred: got %h want 0", ras_pred); end
    n_checks++;
    if ({ras_mispredict, ras_overflow, ras_underflow} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000", {ras_mispredict, ras_overflow, ras_underflow});
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 64'h77, 64'h66, 64'h0A);
      n_checks++; if (pc !== 64'h0A) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want 0a", i, pc); end
      n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL seq_empty[%0d]: got %b want 1", i, ras_empty); end
    end
  endtask

  task automatic test_jxx();
    do_cycle(1'b0, 1'b0, 4'h7, 1'b0, 64'h100, 64'h55, 64'h09);
    n_checks++; if (pc !== 64'h09) begin n_fail++; $display("FAIL jxx_nt: got %h want 09", pc); end
    do_cycle(1'b0, 1'b0, 4'h7, 1'b1, 64'h100, 64'h55, 64'h09);
    n_checks++; if (pc !== 64'h100) begin n_fail++; $display("FAIL jxx_t: got %h want 100", pc); end
    do_cycle(1'b0, 1'b0, 4'hA, 1'b1, 64'h100, 64'h55, 64'h21);
    n_checks++; if (pc !== 64'h21) begin n_fail++; $display("FAIL other_icode: got %h want 21", pc); end
  endtask

  task automatic test_call_ret();
    do_cycle(1'b0, 1'b0, 4'h8, 1'b0, 64'h200, 64'h0, 64'h40);
    n_checks++; if (pc !== 64'h200) begin n_fail++; $display("FAIL call_pc: got %h want 200", pc); end
    n_checks++; if (ras_pred !== m_pred()) begin n_fail++; $display("FAIL call_pred: got %h want %h", ras_pred, m_pred()); end
    do_cycle(1'b0, 1'b0, 4'h9, 1'b0, 64'h0, 64'h40, 64'h201);
    n_checks++; if (pc !== 64'h40) begin n_fail++; $display("FAIL ret_pc: got %h want 40", pc); end
    n_checks++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL ret_mis: got %b want 0", ras_mispredict); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_overflow();
    do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 64'h0, 64'h0, 64'h0);
    for (int i = 1; i <= 9; i++) begin
      do_cycle(1'b0, 1'b0, 4'h8, 1'b0, 64'h300, 64'h0, 64'(i));
      n_checks++; if (ras_overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf[%0d]: got %b want %b", i, ras_overflow, exp_ovf); end
      n_checks++; if (ras_full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL full[%0d]: got %b", i, ras_full); end
    end
    for (int v = 9; v >= 2; v--) begin
      n_checks++; if (ras_pred !== m_pred()) begin n_fail++; $display("FAIL ovf_pred[%0d]: got %h want %h", v, ras_pred, m_pred()); end
      do_cycle(1'b0, 1'b0, 4'h9, 1'b0, 64'h0, 64'(v), 64'h0);
      n_checks++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL ovf_mis[%0d]: got %b want 0", v, ras_mispredict); end
      n_checks++; if (ras_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear[%0d]: got %b want 0", v, ras_overflow); end
    end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_underflow();
    do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 64'h0, 64'h0, 64'h0);
    do_cycle(1'b0, 1'b0, 4'h9, 1'b0, 64'h0, 64'h55, 64'h0);
    n_checks++; if (pc !== 64'h55) begin n_fail++; $display("FAIL unf_pc: got %h want 55", pc); end
    n_checks++; if (ras_underflow !== exp_unf) begin n_fail++; $display("FAIL unf_pulse: got %b want %b", ras_underflow, exp_unf); end
    n_checks++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL unf_mis: got %b want 0", ras_mispredict); end
    do_cycle(1'b0, 1'b0, 4'h8, 1'b0, 64'h400, 64'h0, 64'h10);
    n_checks++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", ras_underflow); end
    do_cycle(1'b0, 1'b0, 4'h9, 1'b0, 64'h0, 64'h99, 64'h0);
    n_checks++; if (ras_mispredict !== exp_mis) begin n_fail++; $display("FAIL mis_pulse: got %b want %b", ras_mispredict, exp_mis); end
    n_checks++; if (pc !== 64'h99) begin n_fail++; $display("FAIL mis_pc: got %h want 99", pc); end
    do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h0, 64'h12);
    n_checks++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", ras_mispredict); end
  endtask

  task automatic test_stall();
    logic [63:0] pc_before, pred_before;
    logic        empty_before;
    do_cycle(1'b0, 1'b0, 4'h8, 1'b0, 64'h500, 64'h0, 64'h30);
    pc_before = pc; pred_before = ras_pred; empty_before = ras_empty;
    do_cycle(1'b0, 1'b1, 4'h8, 1'b0, 64'h600, 64'h0, 64'h31);
    n_checks++; if (pc !== 64'h500) begin n_fail++; $display("FAIL stall_pc: got %h want 500", pc); end
    n_checks++; if (ras_pred !== m_pred()) begin n_fail++; $display("FAIL stall_pred: got %h want %h", ras_pred, m_pred()); end
    n_checks++; if (ras_empty !== (q.size() == 0)) begin n_fail++; $display("FAIL stall_empty: got %b", ras_empty); end
    do_cycle(1'b0, 1'b1, 4'h9, 1'b0, 64'h0, 64'h77, 64'h0);
    n_checks++; if (ras_underflow !== 1'b0 || ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL stall_pulses: got %b%b want 00", ras_underflow, ras_mispredict); end
    n_checks++; if (pc !== pc_before || ras_pred !== pred_before || ras_empty !== empty_before) begin
      n_fail++; $display("FAIL stall_hold: got pc %h pred %h want pc %h pred %h", pc, ras_pred, pc_before, pred_before);
    end
    do_cycle(1'b1, 1'b1, 4'h8, 1'b0, 64'h700, 64'h0, 64'h32);
    n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rst_stall_pc: got %h want %h", pc, RST_PC); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL rst_stall_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_random();
    logic [3:0]  ic;
    logic [63:0] vm;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       ic = 4'h8;
        1:       ic = 4'h9;
        2:       ic = 4'h7;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      vm = ($urandom_range(0, 1) == 1) ? m_pred() : 64'($urandom_range(0, 255));
      do_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), ic, 1'($urandom_range(0, 1)),
               {32'($urandom), 32'($urandom)}, vm, 64'($urandom_range(0, 4095)));
      n_checks++;
      if (pc !== exp_pc || ras_pred !== m_pred() || ras_empty !== (q.size() == 0) || ras_full !== (q.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: got pc %h pred %h e%b f%b want pc %h pred %h e%b f%b", i, pc, ras_pred,
                 ras_empty, ras_full, exp_pc, m_pred(), (q.size() == 0), (q.size() == DEPTH));
      end
      n_checks++;
      if ({ras_mispredict, ras_overflow, ras_underflow} !== {exp_mis, exp_ovf, exp_unf}) begin
        n_fail++;
        $display("FAIL rnd_pulses[%0d]: got %b want %b", i, {ras_mispredict, ras_overflow, ras_underflow},
                 {exp_mis, exp_ovf, exp_unf});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jxx();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
